register_8_bit_serializer: RTL and testbench
============================================

# register_8_bit_serializer

Parallel-in, serial-out transmitter for 8-bit register contents. It accepts one word over a valid/ready handshake and shifts it out LSB-first on a single line, framed by a start bit and a stop bit, with an optional even-parity bit. It sits at the output of the 8-bit register bank and turns the parallel register value into a serial stream. The matching deserializer consumes that stream.

## Interface
- DATA_W, 8: word width in bits; legal range 1..16.
- BIT_CYCLES, 4: clock cycles per serial bit; legal range 1..255.
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- d_in  input  DATA_W  parallel word to transmit; sampled only on handshake.
- d_valid  input  1  d_in holds a word to send.
- d_ready  output  1  block can accept a word; equals (state==IDLE) && !reset.
- ser_out  output  1  serial line; idle level is 1; registered.
- busy  output  1  frame in progress; high in every state except IDLE.
- done  output  1  one-cycle pulse on the last clock of the stop bit.

## Operation
- The block has one clock and one reset. Reset is synchronous and active-high.
- Handshake: a word is accepted on a rising edge where d_valid && d_ready. d_in is copied into the shift register, and parity is computed from that copy.
- While d_ready is low, d_valid is ignored. The requester must hold d_valid and d_in stable until acceptance.
- FSM states:
  - IDLE: ser_out=1. On handshake, go to START.
  - START: ser_out=0 for BIT_CYCLES cycles, then go to DATA.
  - DATA: ser_out = shift_reg[0]. Shift right once every BIT_CYCLES cycles. After DATA_W bits, go to PARITY if enabled, else go to STOP.
  - PARITY: ser_out = ^word, which is even parity. Lasts BIT_CYCLES cycles, then go to STOP.
  - STOP: ser_out=1 for BIT_CYCLES cycles. done is asserted on the final cycle. Then go to IDLE.
- Bit timer: counts 0..BIT_CYCLES-1 and wraps to 0 at each bit boundary. It is cleared on handshake and on reset.
- Bit index: counts 0..DATA_W-1 and is valid only in DATA.
- Reset values: ser_out=1, busy=0, done=0, d_ready=0 while reset is high and 1 on the first cycle after, state=IDLE, counters=0, shift_reg=0.
- Reset mid-frame: on the next edge the FSM returns to IDLE and ser_out goes to 1. The word in flight is discarded and done does not pulse.
- Back-to-back frames: d_ready rises the cycle after done. The minimum gap between two frames is one IDLE cycle with ser_out=1.

## Timing
- The handshake at edge T drives START onto ser_out from T+1.
- Bit k (k=0 for the start bit) occupies cycles T+1+k·BIT_CYCLES through T+(k+1)·BIT_CYCLES.
- Frame length F = (DATA_W+2)·BIT_CYCLES cycles, or (DATA_W+3)·BIT_CYCLES with parity enabled.
- done is high during cycle T+F. d_ready is high from T+F+1.
- ser_out, busy and done are registered. d_ready is decoded from state.

## Configuration
- SERIALIZER_PARITY_EN:
  - Defined: the PARITY state is compiled in and one even-parity bit is sent between the data bits and the stop bit.
  - Undefined: the PARITY state and the parity logic are removed, and DATA goes straight to STOP.

## Structure
- Shared package serializer_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - the constant SER_IDLE_LEVEL = 1'b1;
  - default values for DATA_W and BIT_CYCLES.
- One sub-module, serializer_bit_timer: a BIT_CYCLES modulo counter with synchronous clear. It outputs bit_tick on its terminal count.

## Test plan
- A5, no parity, BIT_CYCLES=4: send d_in=8'hA5 with d_valid held. Expected ser_out bits are 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses exactly 40 cycles after the handshake, and d_ready rises 1 cycle later.
- Parity enabled, BIT_CYCLES=1: send d_in=8'h07. Expected bits are 0,1,1,1,0,0,0,0,0,1(parity),1(stop). d_in=8'h03 gives parity bit 0.
- Back-to-back, BIT_CYCLES=1: hold d_valid high with words 8'hFF then 8'h00. Expect exactly one idle-high cycle between the frames and exactly two done pulses.
- Valid while busy: change d_in to 8'h3C in the middle of a frame. The frame in progress is unchanged, and 8'h3C is sent only after d_ready returns.
- Reset mid-frame: assert reset during DATA bit 3 for one cycle. Expect ser_out=1, busy=0 and d_ready=0 on the next edge, d_ready=1 one cycle after reset drops, no done pulse, and a fresh 8'h5A then transmits correctly.
- Reset values: hold reset for 3 cycles with d_valid=1. Expect ser_out=1, busy=0, done=0 and d_ready=0 throughout, and no word accepted.

Source files
------------

// File: rtl/register_8_bit_serializer_pkg.sv
// serializer_pkg: shared state encoding, idle line level and default sizing for the serializer.
package serializer_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   localparam logic SER_IDLE_LEVEL = 1'b1;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_BIT_CYCLES = 4;
endpackage

// File: rtl/register_8_bit_serializer_if.sv
// register_8_bit_serializer_if: valid/ready word handshake into the serializer.
interface register_8_bit_serializer_if #(parameter int DATA_W = serializer_pkg::DEF_DATA_W);
   logic [DATA_W-1:0] d_in;
   logic d_valid;
   logic d_ready;
   modport master (output d_in, d_valid, input d_ready);
   modport slave (input d_in, d_valid, output d_ready);
endinterface

// File: rtl/register_8_bit_serializer_bit_timer.sv
// serializer_bit_timer: BIT_CYCLES modulo counter with synchronous clear; flags the terminal count.
module serializer_bit_timer #(
   parameter int BIT_CYCLES = serializer_pkg::DEF_BIT_CYCLES
) (
   input  logic clk,
   input  logic clear_i,
   output logic bit_tick_o,
   output logic pre_tick_o
);
   localparam int CW = BIT_CYCLES > 1 ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign bit_tick_o = cnt_q == LAST;
   assign cnt_d = (clear_i || bit_tick_o) ? '0 : cnt_q + 1'b1;
   // Lets the owner register outputs that must line up with the next terminal count.
   assign pre_tick_o = cnt_d == LAST;
   always_ff @(posedge clk) begin
      cnt_q <= cnt_d;
   end
endmodule

// File: rtl/register_8_bit_serializer.sv
// register_8_bit_serializer: framed LSB-first serial transmitter (start, data, stop).
// Define SERIALIZER_PARITY_EN to insert an even-parity bit before the stop bit.
module register_8_bit_serializer
   import serializer_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   register_8_bit_serializer_if.slave bus,
   output logic ser_out,
   output logic busy,
   output logic done
);
   localparam int IW = DATA_W > 1 ? $clog2(DATA_W) : 1;
   state_t state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [IW-1:0] idx_q, idx_d;
   logic ser_q, busy_q, done_q, ser_d;
   logic hs, bit_tick, pre_tick, last_bit, shift;
`ifdef SERIALIZER_PARITY_EN
   logic par_q;
`endif
   assign bus.d_ready = state_q == IDLE && !reset;
   assign hs = bus.d_valid && bus.d_ready;
   assign last_bit = idx_q == IW'(DATA_W - 1);
   assign shift = state_q == DATA && bit_tick;
   assign ser_out = ser_q;
   assign busy = busy_q;
   assign done = done_q;
   serializer_bit_timer #(.BIT_CYCLES(BIT_CYCLES)) u_timer (
      .clk(clk),
      .clear_i(reset || hs),
      .bit_tick_o(bit_tick),
      .pre_tick_o(pre_tick)
   );
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (hs) state_d = START;
         START: if (bit_tick) state_d = DATA;
`ifdef SERIALIZER_PARITY_EN
         DATA: if (bit_tick && last_bit) state_d = PARITY;
         PARITY: if (bit_tick) state_d = STOP;
`else
         DATA: if (bit_tick && last_bit) state_d = STOP;
`endif
         STOP: if (bit_tick) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (reset) state_d = IDLE;
      shreg_d = hs ? bus.d_in : shift ? shreg_q >> 1 : shreg_q;
      idx_d = hs ? '0 : shift ? (last_bit ? '0 : idx_q + 1'b1) : idx_q;
      // Outputs are registered, so they are decoded from the state being entered.
`ifdef SERIALIZER_PARITY_EN
      ser_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : state_d == PARITY ? par_q : SER_IDLE_LEVEL;
`else
      ser_d = state_d == START ? 1'b0 : state_d == DATA ? shreg_d[0] : SER_IDLE_LEVEL;
`endif
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         idx_q <= '0;
         ser_q <= SER_IDLE_LEVEL;
         busy_q <= 1'b0;
         done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         par_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         idx_q <= idx_d;
         ser_q <= ser_d;
         busy_q <= state_d != IDLE;
         done_q <= state_d == STOP && pre_tick;
`ifdef SERIALIZER_PARITY_EN
         par_q <= hs ? ^bus.d_in : par_q;
`endif
      end
   end
endmodule

// File: tb/tb_register_8_bit_serializer.sv
// tb_register_8_bit_serializer: frame-level model plus directed literal frames for the serializer.
module tb_register_8_bit_serializer;
   localparam int BC = 4;
   localparam int DW = 8;
`ifdef SERIALIZER_PARITY_EN
   localparam int NB = 11;
   localparam logic [10:0] E_A5 = 11'b10101001010;
   localparam logic [10:0] E_07 = 11'b11000001110;
   localparam logic [10:0] E_03 = 11'b10000000110;
   localparam logic [10:0] E_5A = 11'b10010110100;
`else
   localparam int NB = 10;
   localparam logic [10:0] E_A5 = 11'b01101001010;
   localparam logic [10:0] E_07 = 11'b01000001110;
   localparam logic [10:0] E_03 = 11'b01000000110;
   localparam logic [10:0] E_5A = 11'b01010110100;
`endif
   localparam int F = NB * BC;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic ser_out, busy, done;
   int total = 0;
   int bad = 0;
   register_8_bit_serializer_if #(.DATA_W(DW)) bus ();
   register_8_bit_serializer #(.DATA_W(DW), .BIT_CYCLES(BC)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .ser_out(ser_out),
      .busy(busy),
      .done(done)
   );
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask
   // Bit k of a frame: 0 = start, 1..DW = data LSB first, then optional parity, then stop.
   function automatic logic exp_bit(input int k, input logic [7:0] w);
      if (k == 0) return 1'b0;
      if (k <= DW) return w[k-1];
`ifdef SERIALIZER_PARITY_EN
      if (k == DW + 1) return ^w;
`endif
      return 1'b1;
   endfunction
   // Model: m_n is the 1-based cycle index inside the current frame.
   logic m_live = 1'b0;
   logic m_on = 1'b0;
   int m_n = 0;
   logic [7:0] m_w = '0;
   always @(posedge clk) begin
      m_live = 1'b1;
      if (reset) begin
         m_on = 1'b0;
         m_n = 0;
      end else if (m_on) begin
         if (m_n == F) m_on = 1'b0;
         else m_n++;
      end else if (bus.d_valid) begin
         m_on = 1'b1;
         m_n = 1;
         m_w = bus.d_in;
      end
   end
   always @(negedge clk) begin
      if (m_live) begin
         chk("ser_out", 32'(ser_out), 32'(m_on ? exp_bit((m_n - 1) / BC, m_w) : 1'b1));
         chk("busy", 32'(busy), 32'(m_on));
         chk("done", 32'(done), 32'(m_on && m_n == F));
         chk("d_ready", 32'(bus.d_ready), 32'(!m_on && !reset));
      end
   end
   task automatic wait_accept();
      bit ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = bus.d_ready;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask
   task automatic send(input logic [7:0] w, output logic [10:0] bits, output int done_at);
      bits = '0;
      done_at = -1;
      bus.d_in = w;
      bus.d_valid = 1'b1;
      wait_accept();
      #1 bus.d_valid = 1'b0;
      for (int c = 1; c <= F + 1; c++) begin
         @(negedge clk);
         if (c <= F && (c - 1) % BC == BC / 2) bits[(c-1)/BC] = ser_out;
         if (done) done_at = c;
      end
   endtask
   initial begin
      logic [10:0] b;
      int da, idle, dn;
      bus.d_in = 8'hA5;
      bus.d_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      bus.d_valid = 1'b0;
      @(negedge clk);
      chk("rst_no_accept_busy", 32'(busy), 32'd0);
      chk("rst_ready_after", 32'(bus.d_ready), 32'd1);
      send(8'hA5, b, da);
      chk("a5_bits", 32'(b), 32'(E_A5));
      chk("a5_done_at", 32'(da), 32'(F));
      chk("a5_ready_after_done", 32'(bus.d_ready), 32'd1);
      send(8'h07, b, da);
      chk("x07_bits", 32'(b), 32'(E_07));
      send(8'h03, b, da);
      chk("x03_bits", 32'(b), 32'(E_03));
      bus.d_in = 8'hFF;
      bus.d_valid = 1'b1;
      wait_accept();
      #1 bus.d_in = 8'h00;
      idle = 0;
      dn = 0;
      for (int c = 1; c <= 2 * F + 1; c++) begin
         @(negedge clk);
         idle += int'(!busy);
         dn += int'(done);
      end
      bus.d_valid = 1'b0;
      chk("b2b_idle_cycles", 32'(idle), 32'd1);
      chk("b2b_done_pulses", 32'(dn), 32'd2);
      bus.d_in = 8'h5A;
      bus.d_valid = 1'b1;
      wait_accept();
      repeat (F / 2) @(posedge clk);
      #1 bus.d_in = 8'h3C;
      wait_accept();
      #1 bus.d_valid = 1'b0;
      repeat (F + 2) @(posedge clk);
      bus.d_in = 8'h5A;
      bus.d_valid = 1'b1;
      wait_accept();
      #1 bus.d_valid = 1'b0;
      repeat (4 * BC) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_ser_out", 32'(ser_out), 32'd1);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_ready", 32'(bus.d_ready), 32'd1);
      send(8'h5A, b, da);
      chk("x5a_bits", 32'(b), 32'(E_5A));
      chk("x5a_done_at", 32'(da), 32'(F));
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end
endmodule
